// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and defaults for the context-switching register file
package reg_file_pkg;

    localparam int RF_W_DEF  = 8;
    localparam int RF_AW_DEF = 3;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_SAVE,
        RF_RESTORE
    } rf_state_e;

endpackage

// File: rtl/rf_ctx_fsm.sv
// rtl/rf_ctx_fsm.sv - save/restore sequencer: state, copy index and done pulse
module rf_ctx_fsm
    import reg_file_pkg::*;
#(
    parameter int AW = RF_AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          save_req,
    input  logic          restore_req,
    output logic          busy,
    output logic          done,
    output logic          copy_save,
    output logic          copy_restore,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

    rf_state_e     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                // save has priority when both requests arrive together
                if (save_req) begin
                    state_d = RF_SAVE;
                    idx_d   = '0;
                end else if (restore_req) begin
                    state_d = RF_RESTORE;
                    idx_d   = '0;
                end
            end
            RF_SAVE, RF_RESTORE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = RF_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign busy         = (state_q != RF_IDLE);
    assign copy_save    = (state_q == RF_SAVE);
    assign copy_restore = (state_q == RF_RESTORE);
    assign idx          = idx_q;
    assign done         = done_q;

endmodule

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - parametrised register file with bypass and shadow-bank context save/restore
module reg_file_ctx
    import reg_file_pkg::*;
#(
    parameter int W      = RF_W_DEF,
    parameter int AW     = RF_AW_DEF,
    parameter int BYPASS = 1,
    parameter int IMP0   = 0,
    parameter int IMP1   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  dat_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    output logic          wr_ready,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [W-1:0]  datA_out,
    output logic [W-1:0]  datB_out,
    output logic [W-1:0]  implicitReg1,
    output logic [W-1:0]  implicitReg2,
    input  logic          save_req,
    input  logic          restore_req,
    output logic          busy,
    output logic          done
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic          BYP_EN   = (BYPASS != 0);
    localparam logic [AW-1:0] IMP0_IDX = AW'(IMP0);
    localparam logic [AW-1:0] IMP1_IDX = AW'(IMP1);

    logic [W-1:0]  core_q   [DEPTH];
    logic [W-1:0]  core_d   [DEPTH];
    logic [W-1:0]  shadow_q [DEPTH];
    logic [W-1:0]  shadow_d [DEPTH];

    logic          copy_save;
    logic          copy_restore;
    logic [AW-1:0] idx;
    logic          wr_fire;

    rf_ctx_fsm #(
        .AW(AW)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .save_req     (save_req),
        .restore_req  (restore_req),
        .busy         (busy),
        .done         (done),
        .copy_save    (copy_save),
        .copy_restore (copy_restore),
        .idx          (idx)
    );

    assign wr_ready = !busy;
    assign wr_fire  = wr_en && wr_ready;

    // host writes and restore copies never coincide: a restore holds busy
    always_comb begin
        core_d   = core_q;
        shadow_d = shadow_q;
        if (wr_fire) begin
            core_d[wr_addr] = dat_in;
        end
        if (copy_restore) begin
            core_d[idx] = shadow_q[idx];
        end
        if (copy_save) begin
            shadow_d[idx] = core_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                core_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            core_q   <= core_d;
            shadow_q <= shadow_d;
        end
    end

    assign datA_out = (BYP_EN && wr_fire && (wr_addr == rd_addrA)) ? dat_in : core_q[rd_addrA];
    assign datB_out = (BYP_EN && wr_fire && (wr_addr == rd_addrB)) ? dat_in : core_q[rd_addrB];

    // implicit operands always reflect committed state, never the bypass path
    assign implicitReg1 = core_q[IMP0_IDX];
    assign implicitReg2 = core_q[IMP1_IDX];

endmodule

// File: doc/reg_file_ctx.md
Name: reg_file_ctx

Overview:
Parametrised successor to the 8x8 core register file, with configurable width, depth and implicit-register indices. Adds optional write-to-read bypass, asynchronous clear, and a shadow bank. A save/restore FSM copies the whole active bank to or from the shadow bank, one register per cycle, for interrupt/context switches. Sits between the ALU result mux (write side) and the operand/branch-compare paths (read side).

Parameters:
W, 8, data width of each register
AW, 3, address width; DEPTH = 2**AW registers in each bank
BYPASS, 1, 1 = same-cycle write data forwarded to read ports A/B
IMP0, 0, index driven on implicitReg1
IMP1, 3, index driven on implicitReg2

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
dat_in  in  W  write data
wr_en  in  1  write request
wr_addr  in  AW  write address
wr_ready  out  1  write accepted this cycle; equals !busy
rd_addrA  in  AW  read address A
rd_addrB  in  AW  read address B
datA_out  out  W  read data A, combinational
datB_out  out  W  read data B, combinational
implicitReg1  out  W  core[IMP0], combinational, never bypassed
implicitReg2  out  W  core[IMP1], combinational, never bypassed
save_req  in  1  start copy core -> shadow
restore_req  in  1  start copy shadow -> core
busy  out  1  copy in progress
done  out  1  one-cycle pulse after the final copy

Behaviour:
- Reset: while rst_n=0, all core and shadow entries are 0, state=RF_IDLE, idx=0, busy=0, done=0. Reset takes effect immediately, including mid-copy; a partial copy is discarded.
- Write: if wr_en && wr_ready, core[wr_addr] <= dat_in at the clock edge. wr_en while busy is dropped, not queued.
- Reads: combinational from core. If BYPASS=1 and wr_en && wr_ready && wr_addr==rd_addrX, datX_out=dat_in. Otherwise datX_out=core[rd_addrX].
- FSM states: RF_IDLE, RF_SAVE, RF_RESTORE.
- RF_IDLE:
  - save_req -> RF_SAVE, idx<=0.
  - else restore_req -> RF_RESTORE, idx<=0.
  - If both are asserted, save wins and restore_req is ignored.
- RF_SAVE, each cycle: shadow[idx] <= core[idx]; idx <= idx+1.
- RF_RESTORE, each cycle: core[idx] <= shadow[idx]; idx <= idx+1.
- End of copy: when idx==DEPTH-1, the last copy occurs, state -> RF_IDLE and done <= 1 for exactly one cycle. idx wraps to 0.
- busy=1 exactly when state != RF_IDLE, i.e. for DEPTH cycles starting the cycle after the request is sampled.
- save_req/restore_req while busy: ignored, no restart.
- A request may be asserted again in the cycle done is high: state is IDLE, so it is accepted.
- wr_en in the same cycle as an accepted save_req: the write lands in core at that edge (still IDLE). The save then captures the new value.
- Reads during a copy are legal, but data may be mid-restore. Consumers must stall on busy.
- Address range: full, since DEPTH=2**AW.
- All arithmetic is unsigned. idx is AW bits and wraps naturally.

Decomposition:
- Package reg_file_pkg:
  - typedef enum logic[1:0] rf_state_e {RF_IDLE, RF_SAVE, RF_RESTORE}
  - localparams RF_W_DEF=8, RF_AW_DEF=3
- Sub-module rf_ctx_fsm: contains state register, idx counter and done pulse. Outputs busy, idx, copy_save and copy_restore strobes. reg_file_ctx holds both arrays, the write/bypass muxing and the copy datapath.

Test Plan:
- Reset: write core[2]=0x5A, pulse rst_n low mid-cycle -> all reads return 0x00 immediately (async); busy=0, done=0.
- Bypass: wr_en=1, wr_addr=4, dat_in=0xC3, rd_addrA=4, rd_addrB=4, BYPASS=1 -> datA_out=datB_out=0xC3 in the same cycle; implicit outputs unchanged. With BYPASS=0, the old value shows until the next edge.
- Save/restore round trip:
  - Load core[i]=0x10+i, assert save_req one cycle -> busy high 8 cycles, done pulses once on cycle 9.
  - Overwrite all core with 0xFF, then restore_req -> after done, core[i]=0x10+i and implicitReg2=0x13.
- Writes dropped while busy: wr_en=1, wr_addr=1, dat_in=0xAA during SAVE -> wr_ready=0 and core[1] unchanged.
  - Same write in the cycle save_req is accepted -> core[1]=0xAA and shadow[1]=0xAA after done.
- Request collision: save_req and restore_req together in IDLE -> RF_SAVE is taken. A second save_req mid-copy -> ignored; busy stays exactly 8 cycles, single done.
- Reset mid-restore: assert rst_n=0 at idx=3 of RF_RESTORE -> state IDLE, core and shadow all 0. After release, the next save_req completes normally in 8 cycles.
